sync_load_down_counter: RTL and testbench
=========================================

# sync_load_down_counter

Loadable synchronous down counter and timer, the decrementing companion to the team's loadable up counter. It takes a start value, counts down to zero under an enable, and flags expiry with a one-cycle terminal-count pulse. It can stop at zero (one-shot) or reload the captured start value (periodic). It sits beside the up counter in the basic counter library and serves as a timeout or period generator.

## Interface
- WIDTH, 4, counter and load-value width in bits

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  synchronous load strobe; captures d_in
- d_in  input  WIDTH  start value; also stored as the reload value
- en  input  1  count enable; the counter decrements only when high
- auto_reload  input  1  1 = periodic, 0 = one-shot; sampled at each expiry
- count  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle wide
- busy  output  1  high while in RUN

## Operation
- Reset (async, active-high): count=0, reload_reg=0, state=IDLE, tc=0, busy=0.
- FSM states:
  - IDLE: count holds.
  - RUN: count decrements on each enabled cycle.
- Priority, highest first: rst, load, decrement.
- load=1, any state: count<=d_in and reload_reg<=d_in on the same edge.
  - Next state is RUN if d_in!=0, IDLE if d_in==0.
  - en is ignored in that cycle.
  - Loading while in RUN restarts the count; any pending expiry is cancelled.
- RUN, en=1, count>1: count<=count-1.
- RUN, en=1, count==1 (expiry):
  - tc<=1 for one cycle.
  - auto_reload=1: count<=reload_reg, stay in RUN.
  - auto_reload=0: count<=0, go to IDLE.
- RUN, en=0: count holds, tc=0, state holds.
- IDLE: en is ignored and count holds; tc=0.
- The count never wraps below zero, so there is no 0 -> all-ones transition.
- load of 0: count=0, IDLE, no tc pulse.
- load of all-ones: count runs down from 2^WIDTH-1 with no overflow.
- busy = (state==RUN).

## Timing
- Load latency: count shows d_in one cycle after the load edge.
- The first decrement occurs on the following enabled edge.
- One-shot: load of N (N>=1) with en held high gives tc exactly N cycles after the load edge.
  - tc is coincident with count==0 and busy falling.
- Periodic: tc repeats every reload_reg enabled cycles.
  - count sequence: N, N-1, …, 1, N, …
  - count is never 0 while auto-reloading.
- en gaps stretch the period 1:1; tc cannot fire while en=0.
- Simultaneous load and expiry: load wins and tc stays 0.
- rst mid-count: all outputs clear immediately, not waiting for a clock edge; reload_reg is lost.
- auto_reload may change at any time; only its value on the expiry edge matters.

## Structure
- Shared package counter_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_RUN=1'b1
  - default width constant CNT_WIDTH=4, shared with the up counter
- Single module, no sub-module: one state register, one count register, one reload register, one registered tc.
- Implementation target: roughly 120–180 lines of RTL.

## Test plan
All scenarios use WIDTH=4 and a 10-unit clock.
1. rst pulse mid-count from 4'b0111 -> count=0, busy=0, tc=0 immediately, before the next clock edge.
2. load 4'b0101, en=1, auto_reload=0 -> count 5,4,3,2,1,0; tc high only on the 0 cycle; busy falls with it; count then holds 0.
3. load 4'b0011, en=1, auto_reload=1 -> count 3,2,1,3,2,1,…; tc every 3 cycles; busy stays 1.
4. load 4'b1010, en toggled 1,0,1,0 -> count decrements only on en=1 cycles; tc delayed by exactly the number of en=0 cycles.
5. load 4'b0010 and count reaches 1; on the expiry edge, load 4'b1111 -> tc=0, count=15, stays in RUN.
6. load 4'b0000 with en=1 -> count=0, busy=0, tc never asserts; load 4'b1111 -> 15 cycles to tc with no wrap.

Source files
------------

// File: rtl/counter_pkg.sv
// ============================================================================
//  Module      : counter_pkg
//  Description : Shared constants for the basic counter library.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam int unsigned CNT_WIDTH = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/sync_load_down_counter.sv
// ============================================================================
//  Module      : sync_load_down_counter
//  Description : Loadable down counter / timer with one-shot or periodic reload
//                and a registered one-cycle terminal-count pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_load_down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  logic             w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_tc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= c_zero;
      r_reload <= c_zero;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;

    if (load) begin
      // A load overrides any expiry landing on the same edge.
      w_count_nxt  = d_in;
      w_reload_nxt = d_in;
      w_state_nxt  = (d_in != c_zero) ? ST_RUN : ST_IDLE;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (en) begin
            if (r_count == c_one) begin
              w_tc_nxt = 1'b1;
              if (auto_reload) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = c_zero;
                w_state_nxt = ST_IDLE;
              end
            end else if (r_count == c_zero) begin
              // Unreachable in normal operation; park safely instead of wrapping.
              w_state_nxt = ST_IDLE;
            end else begin
              w_count_nxt = r_count - c_one;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == ST_RUN);

endmodule : sync_load_down_counter

`default_nettype wire

// File: tb/tb_sync_load_down_counter.sv
// ============================================================================
//  Module      : tb_sync_load_down_counter
//  Description : Directed self-checking bench with an expected-value queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_load_down_counter;

  localparam int unsigned c_width = 4;

  typedef struct packed {
    logic [c_width-1:0] count;
    logic               tc;
    logic               busy;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               load;
  logic [c_width-1:0] d_in;
  logic               en;
  logic               auto_reload;
  logic [c_width-1:0] count;
  logic               tc;
  logic               busy;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;

  sync_load_down_counter #(.WIDTH(c_width)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .d_in        (d_in),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int c, input logic t, input logic b);
    exp_t e;
    e.count = c_width'(c);
    e.tc    = t;
    e.busy  = b;
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    exp_t o;
    o = {count, tc, busy};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, observed count=%0d tc=%0b busy=%0b",
               tag, count, tc, busy);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed count=%0d tc=%0b busy=%0b, expected count=%0d tc=%0b busy=%0b",
               tag, o.count, o.tc, o.busy, e.count, e.tc, e.busy);
      end
    end
  endtask

  // Drive one clock of stimulus (from a negedge), then compare just after the edge.
  task automatic cycle(input logic ld, input int d, input logic e, input logic ar,
                       input int xc, input logic xt, input logic xb, input string tag);
    load        = ld;
    d_in        = c_width'(d);
    en          = e;
    auto_reload = ar;
    push(xc, xt, xb);
    @(posedge clk);
    #1;
    check(tag);
    @(negedge clk);
  endtask

  initial begin
    int c;
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1; load = 1'b0; d_in = '0; en = 1'b0; auto_reload = 1'b0;

    #2;
    push(0, 1'b0, 1'b0);
    check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // One-shot from 5
    cycle(1'b1, 5, 1'b1, 1'b0, 5, 1'b0, 1'b1, "oneshot_load");
    for (int k = 4; k >= 1; k--)
      cycle(1'b0, 0, 1'b1, 1'b0, k, 1'b0, 1'b1, "oneshot_dec");
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, "oneshot_tc");
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "oneshot_hold0");
    cycle(1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "idle_hold0");

    // Periodic from 3, then drop auto_reload before the last expiry
    cycle(1'b1, 3, 1'b1, 1'b1, 3, 1'b0, 1'b1, "periodic_load");
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 2)
        cycle(1'b0, 0, 1'b1, 1'b1, 3, 1'b1, 1'b1, "periodic_reload");
      else
        cycle(1'b0, 0, 1'b1, 1'b1, 2 - (k % 3), 1'b0, 1'b1, "periodic_dec");
    end
    cycle(1'b0, 0, 1'b1, 1'b0, 2, 1'b0, 1'b1, "ar_off_dec");
    cycle(1'b0, 0, 1'b1, 1'b0, 1, 1'b0, 1'b1, "ar_off_dec");
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, "ar_off_tc");

    // Enable gaps from 10: ten enabled edges interleaved with nine idle ones
    cycle(1'b1, 10, 1'b0, 1'b0, 10, 1'b0, 1'b1, "gap_load");
    c = 10;
    for (int k = 0; k < 19; k++) begin
      if (k % 2 == 0) c--;
      cycle(1'b0, 0, (k % 2 == 0), 1'b0, c, (k == 18), (k != 18),
            (k == 18) ? "gap_tc" : "gap_step");
    end

    // Asynchronous reset mid-count from 7
    cycle(1'b1, 7, 1'b0, 1'b0, 7, 1'b0, 1'b1, "rst_pre_load");
    cycle(1'b0, 0, 1'b0, 1'b0, 7, 1'b0, 1'b1, "rst_pre_hold");
    rst = 1'b1;
    #1;
    push(0, 1'b0, 1'b0);
    check("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "post_rst_idle");

    // Load colliding with expiry
    cycle(1'b1, 2, 1'b1, 1'b0, 2, 1'b0, 1'b1, "collide_load");
    cycle(1'b0, 0, 1'b1, 1'b0, 1, 1'b0, 1'b1, "collide_dec");
    cycle(1'b1, 15, 1'b1, 1'b0, 15, 1'b0, 1'b1, "collide_reload");
    cycle(1'b0, 0, 1'b1, 1'b0, 14, 1'b0, 1'b1, "collide_run");

    // Load of zero, then full-scale countdown without wrap
    cycle(1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "load_zero");
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "zero_idle");
    cycle(1'b0, 0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "zero_idle");
    cycle(1'b1, 15, 1'b1, 1'b0, 15, 1'b0, 1'b1, "full_load");
    for (int k = 14; k >= 1; k--)
      cycle(1'b0, 0, 1'b1, 1'b0, k, 1'b0, 1'b1, "full_dec");
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, "full_tc");
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "full_nowrap");

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_sync_load_down_counter

`default_nettype wire
